// File: rtl/furnace_pkg.sv
// Shared furnace constants and scheduler state encoding.
// Used by the scheduler RTL and by the furnace model in the bench.
package furnace_pkg;

   localparam int TEMP_W = 7;

   localparam logic [TEMP_W-1:0] TEMP_MIN = 7'd25;
   localparam logic [TEMP_W-1:0] TEMP_MAX = 7'd120;

   // Shared session counter; wide enough for any legal timeout value.
   localparam int CNT_W = 8;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_HOT = 2'd1;
   localparam logic [1:0] ST_LOAD     = 2'd2;
   localparam logic [1:0] ST_RECOVER  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE     = ST_IDLE,
      S_WAIT_HOT = ST_WAIT_HOT,
      S_LOAD     = ST_LOAD,
      S_RECOVER  = ST_RECOVER
   } state_t;

endpackage

// File: rtl/furnace_scheduler_rr_arbiter.sv
// Combinational round-robin pick: searches upward from ptr, wrapping.
// Ports: req (requests), ptr (start index), pick (one-hot), pick_idx, any.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [IDX_W-1:0]   pick_idx,
   output logic               any
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      pick     = '0;
      pick_idx = '0;
      any      = 1'b0;
      idx      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (!any && req[idx]) begin
            any       = 1'b1;
            pick[idx] = 1'b1;
            pick_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/furnace_scheduler.sv
// Shares one furnace among NUM_REQ requesters, one session at a time.
// Ports: clock, reset (async high), req, furnace_temp, alarm in;
//        door_sig, usage, grant, busy, done, error out (all registered).
module furnace_scheduler
   import furnace_pkg::*;
#(
   parameter int                NUM_REQ      = 4,
   parameter logic [TEMP_W-1:0] READY_TEMP   = 7'd100,
   parameter int                LOAD_CYCLES  = 8,
   parameter int                HEAT_TIMEOUT = 63
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic [TEMP_W-1:0]  furnace_temp,
   input  logic               alarm,
   output logic               door_sig,
   output logic               usage,
   output logic [NUM_REQ-1:0] grant,
   output logic               busy,
   output logic               done,
   output logic               error
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(HEAT_TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               err_s, err_s_n;
   logic [IDX_W-1:0]   ptr, ptr_n;
   logic [IDX_W-1:0]   owner, owner_n;
   logic [IDX_W-1:0]   next_ptr;
   logic [NUM_REQ-1:0] grant_n;
   logic               door_q, door_n;
   logic               busy_n, done_n, error_n;

   logic [NUM_REQ-1:0] pick;
   logic [IDX_W-1:0]   pick_idx;
   logic               any_req;
   logic               hot, held;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req      (req),
      .ptr      (ptr),
      .pick     (pick),
      .pick_idx (pick_idx),
      .any      (any_req)
   );

   assign hot  = (furnace_temp >= READY_TEMP);
   assign held = |(req & grant);

   assign next_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;

   // One flop drives both furnace commands, so (0,1) can never appear.
   assign door_sig = door_q;
   assign usage    = door_q;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      err_s_n = err_s;
      ptr_n   = ptr;
      owner_n = owner;
      grant_n = grant;
      done_n  = 1'b0;
      error_n = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (any_req) begin
               state_n = S_WAIT_HOT;
               grant_n = pick;
               owner_n = pick_idx;
               cnt_n   = '0;
               err_s_n = 1'b0;
            end
         end

         // Temperature wins over a dropped request, which wins over timeout.
         S_WAIT_HOT: begin
            cnt_n = cnt + 1'b1;
            if (hot) begin
               state_n = S_LOAD;
               cnt_n   = '0;
            end else if (!held) begin
               state_n = S_IDLE;
               grant_n = '0;
               ptr_n   = next_ptr;
            end else if (cnt == TIMEOUT) begin
               state_n = S_IDLE;
               grant_n = '0;
               ptr_n   = next_ptr;
               error_n = 1'b1;
            end
         end

         S_LOAD: begin
            cnt_n = cnt + 1'b1;
            if (alarm) begin
               err_s_n = 1'b1;
            end
            if (cnt == LOAD_LAST || alarm || !held) begin
               state_n = S_RECOVER;
               cnt_n   = '0;
            end
         end

         // A timeout still closes the session with done, flagged as error.
         S_RECOVER: begin
            cnt_n = cnt + 1'b1;
            if (hot || cnt == TIMEOUT) begin
               state_n = S_IDLE;
               grant_n = '0;
               ptr_n   = next_ptr;
               done_n  = 1'b1;
               error_n = err_s | ~hot;
            end
         end

         default: begin
            state_n = S_IDLE;
            grant_n = '0;
         end
      endcase
   end

   assign door_n = (state_n == S_LOAD);
   assign busy_n = (state_n != S_IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         err_s  <= 1'b0;
         ptr    <= '0;
         owner  <= '0;
         grant  <= '0;
         door_q <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         error  <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         err_s  <= err_s_n;
         ptr    <= ptr_n;
         owner  <= owner_n;
         grant  <= grant_n;
         door_q <= door_n;
         busy   <= busy_n;
         done   <= done_n;
         error  <= error_n;
      end
   end

endmodule

// File: doc/furnace_scheduler.md
Name: furnace_scheduler

Overview:
- Shares one furnace among NUM_REQ requesters.
- Each session runs in a fixed order: grant, preheat, load, recover.
- Drives the furnace's door_sig/usage inputs and monitors its furnace_temp/alarm outputs.
- Sits between the requester logic and the furnace; round-robin fairness; reports completion or error per session.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- READY_TEMP, 7'd100, temperature at or above which the furnace counts as hot.
- LOAD_CYCLES, 8, clock cycles the door stays open in use.
- HEAT_TIMEOUT, 63, maximum cycles spent in WAIT_HOT or RECOVER before an error is declared.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  level request per requester, held until done or error.
- furnace_temp  in  7  furnace temperature, unsigned.
- alarm  in  1  furnace alarm.
- door_sig  out  1  furnace door command.
- usage  out  1  furnace usage command.
- grant  out  NUM_REQ  one-hot owner of the current session; all-zero when idle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at session end.
- error  out  1  one-cycle pulse, coincident with done or with an abort.

Behaviour:
- Reset values: state=IDLE, all outputs 0, rr pointer=0, counters=0. An async reset mid-session closes the door immediately; no done pulse.
- Timing: outputs are registered on posedge; the furnace samples them on negedge, half a cycle later.
- Invariant: door_sig=0 with usage=1 is never driven. Only the pairs (0,0) and (1,1) appear.
- States (IDLE, WAIT_HOT, LOAD, RECOVER): 2-bit encoding, with a shared cycle counter cnt (6 bits minimum) and a sticky session flag err_s.
- IDLE:
  - door=0, usage=0, so the furnace preheats.
  - If req!=0, the round-robin pick starts at pointer p and searches upward, modulo NUM_REQ.
  - grant is registered next cycle; go to WAIT_HOT; cnt=0, err_s=0.
- WAIT_HOT:
  - door=0, usage=0; cnt increments each cycle.
  - furnace_temp>=READY_TEMP: go to LOAD; cnt=0.
  - Else if the granted req drops: go to IDLE, grant=0, no done, no error.
  - Else if cnt==HEAT_TIMEOUT: error pulse, go to IDLE, grant=0.
  - Priority: temp > req drop > timeout.
- LOAD:
  - door=1, usage=1 from the first cycle of the state.
  - Exit to RECOVER (cnt=0) when any of these holds:
    - cnt==LOAD_CYCLES-1;
    - alarm==1 (furnace hit its 25 floor), which sets err_s;
    - the granted req drops.
  - Alarm is sampled every LOAD cycle, including the last.
- RECOVER:
  - door=0, usage=0; cnt increments.
  - On furnace_temp>=READY_TEMP or cnt==HEAT_TIMEOUT (the timeout sets err_s): done=1 for one cycle, error=err_s, grant=0, go to IDLE.
- Pointer update: on any return to IDLE from a session (done or abort), p = winner+1 mod NUM_REQ.
- Back-to-back sessions: a req still high in IDLE is re-arbitrated on the next cycle. The same requester wins only if it is alone.
- Requests are sampled only in IDLE. Changes to non-granted req bits mid-session are ignored.
- Temperature compares are unsigned, 7-bit; no arithmetic is done on furnace_temp.

Decomposition:
- furnace_pkg holds:
  - TEMP_W=7, TEMP_MIN=7'd25, TEMP_MAX=7'd120;
  - the state encoding localparams;
  - shared with the furnace model and bench.
- Sub-module rr_arbiter (NUM_REQ): combinational one-hot pick from req and pointer p. The registered pointer lives in the parent.

Test Plan:
- Reset, furnace at 50, req=4'b0001 → grant=0001 next cycle; WAIT_HOT lasts about 10 cycles (temp 50→100); LOAD 8 cycles with door=usage=1 (temp 100→84); RECOVER 4 cycles (84→104); done=1, error=0, grant=0.
- req=4'b1011 held continuously → grant sequence 0001, 0010, 1000, 0001, with one IDLE cycle between sessions.
- READY_TEMP=30, LOAD_CYCLES=8 → alarm rises once temp reaches 25 in LOAD; exits to RECOVER early; ends with done=1, error=1.
- Furnace model stuck at 60, HEAT_TIMEOUT=63 → error pulse on WAIT_HOT cycle 64; no done; grant=0; pointer advances.
- Granted req dropped on the 3rd LOAD cycle → door closes the next cycle; RECOVER completes; done=1, error=0.
- reset asserted during LOAD → door_sig, usage, grant and busy go to 0 asynchronously; no done or error pulse.
